// File: rtl/reduction_flag_pkg.sv
// Shared types and the flag reduction helper for the reduction flag pipeline.
// Optional parity checking in the top is enabled by REDUCTION_PARITY_CHECK_EN.
package reduction_flag_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    typedef struct packed {
        logic all;
        logic any;
        logic par;
        logic sel_red;
    } flags_t;

    // data is zero-extended to MAX_W; only the low width bits take part.
    function automatic flags_t reduce_flags(input logic [MAX_W-1:0] data,
                                            input int width,
                                            input logic sel);
        flags_t f;
        f.all = 1'b1;
        f.any = 1'b0;
        f.par = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                f.all = f.all & data[i];
                f.any = f.any | data[i];
                f.par = f.par ^ data[i];
            end
        end
        f.sel_red = sel ? f.par : ~f.par;
        return f;
    endfunction

endpackage

// File: rtl/reduction_flag_pipe_calc.sv
// Combinational reduction flags and masked-byte select for one input beat.
module reduction_flag_calc
    import reduction_flag_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    input  logic             sel,
    output flags_t           flags,
    output logic [WIDTH-1:0] masked
);

    always_comb begin
        flags  = reduce_flags(MAX_W'(data), WIDTH, sel);
        masked = '0;
        if (flags.all) begin
            masked = mask;
        end else if (flags.any) begin
            masked = ~mask;
        end
    end

endmodule

// File: rtl/reduction_flag_pipe.sv
// Registered reduction-flag stage with per-window all/any/parity summary counters.
// Define REDUCTION_PARITY_CHECK_EN to add the in_par_exp input and sticky par_err output.
module reduction_flag_pipe
    import reduction_flag_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  WINDOW = 16,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_all,
    output logic             out_any,
    output logic             out_par,
    output logic             out_sel_red,
    output logic [WIDTH-1:0] out_masked,
    output logic             sum_valid,
    output logic [CNT_W-1:0] sum_all,
    output logic [CNT_W-1:0] sum_any,
    output logic [CNT_W-1:0] sum_par
`ifdef REDUCTION_PARITY_CHECK_EN
    ,
    input  logic             in_par_exp,
    output logic             par_err
`endif
);

    flags_t           calc_flags;
    logic [WIDTH-1:0] calc_masked;
    logic             accept;

    reduction_flag_calc #(.WIDTH(WIDTH)) u_calc (
        .data   (in_data),
        .mask   (in_mask),
        .sel    (in_sel),
        .flags  (calc_flags),
        .masked (calc_masked)
    );

    // ---------------- output handshake register ----------------
    logic             out_valid_q, out_valid_d;
    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] masked_q, masked_d;
    state_t           state_q, state_d;

    assign in_ready = (state_q != REPORT) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        masked_d    = masked_q;
        if (accept) begin
            out_valid_d = 1'b1;
            flags_d     = calc_flags;
            masked_d    = calc_masked;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            masked_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            masked_q    <= masked_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_all     = flags_q.all;
    assign out_any     = flags_q.any;
    assign out_par     = flags_q.par;
    assign out_sel_red = flags_q.sel_red;
    assign out_masked  = masked_q;

    // ---------------- window FSM ----------------
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             sum_load;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        sum_load = 1'b0;
        if (clear) begin
            state_d = IDLE;
            beat_d  = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        cnt_inc = 1'b1;
                        if (beat_q == CNT_W'(WINDOW - 1)) begin
                            state_d = REPORT;
                            beat_d  = '0;
                        end else begin
                            state_d = ACCUM;
                            beat_d  = beat_q + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    sum_load = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // While reporting, the live counters already hold the final window totals.
    assign sum_valid = (state_q == REPORT) & ~clear;

    // ---------------- summary counters: 0=all, 1=any, 2=par ----------------
    logic [2:0]            flag_vec;
    logic [2:0][CNT_W-1:0] sum_vec;

    assign flag_vec = {calc_flags.par, calc_flags.any, calc_flags.all};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] sum_q, sum_d;

            always_comb begin
                cnt_d = cnt_q;
                sum_d = sum_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (cnt_inc) begin
                    cnt_d = cnt_q + CNT_W'(flag_vec[gi]);
                end
                if (sum_load) begin
                    sum_d = cnt_q;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    sum_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    sum_q <= sum_d;
                end
            end

            assign sum_vec[gi] = sum_valid ? cnt_q : sum_q;
        end
    endgenerate

    assign sum_all = sum_vec[0];
    assign sum_any = sum_vec[1];
    assign sum_par = sum_vec[2];

`ifdef REDUCTION_PARITY_CHECK_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q;
        if (clear) begin
            par_err_d = 1'b0;
        end else if (accept && (calc_flags.par != in_par_exp)) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_reduction_flag_pipe.sv
// Self-checking bench for reduction_flag_pipe: directed scenarios plus randomized traffic against a reference model.
module tb_reduction_flag_pipe;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 16;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] in_mask = '0;
    logic             in_sel = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_all, out_any, out_par, out_sel_red;
    logic [WIDTH-1:0] out_masked;
    logic             sum_valid;
    logic [CNT_W-1:0] sum_all, sum_any, sum_par;
`ifdef REDUCTION_PARITY_CHECK_EN
    logic             in_par_exp = 1'b0;
    logic             par_err;
`endif

    always #5 clk = ~clk;

    reduction_flag_pipe #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mask     (in_mask),
        .in_sel      (in_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_all     (out_all),
        .out_any     (out_any),
        .out_par     (out_par),
        .out_sel_red (out_sel_red),
        .out_masked  (out_masked),
        .sum_valid   (sum_valid),
        .sum_all     (sum_all),
        .sum_any     (sum_any),
        .sum_par     (sum_par)
`ifdef REDUCTION_PARITY_CHECK_EN
        ,
        .in_par_exp  (in_par_exp),
        .par_err     (par_err)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state (transaction level)
    bit         m_ov;
    logic [3:0] m_flags;     // {all, any, par, sel_red}
    logic [7:0] m_msk;
    bit         m_rep;
    int         m_n, m_ca, m_cy, m_cp;
    int         m_pa, m_py, m_pp;
    int         m_sa, m_sy, m_sp;
    bit         m_perr;

    function automatic logic [3:0] ref_flags(input logic [7:0] d, input logic s);
        logic a, y, p;
        a = (d == 8'hFF);
        y = (d != 8'h00);
        p = ($countones(d) % 2) == 1;
        return {a, y, p, (s ? p : !p)};
    endfunction

    function automatic logic [7:0] ref_masked(input logic [7:0] d, input logic [7:0] m);
        if (d == 8'hFF) return m;
        if (d != 8'h00) return ~m;
        return 8'h00;
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(0, 3) == 0) r = 8'hFF;
        else if ($urandom_range(0, 4) == 0) r = 8'h00;
        return r;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_flags = '0; m_msk = '0; m_rep = 0; m_perr = 0;
        m_n = 0; m_ca = 0; m_cy = 0; m_cp = 0;
        m_pa = 0; m_py = 0; m_pp = 0;
        m_sa = 0; m_sy = 0; m_sp = 0;
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic [7:0] m,
                          input logic s, input logic ordy, input logic clr);
        in_valid = v; in_data = d; in_mask = m; in_sel = s;
        out_ready = ordy; clear = clr;
        #1;
    endtask

    // Advance the model by one clock using the currently applied inputs, then clock the DUT.
    task automatic cycle();
        bit         rdy, acc;
        logic [3:0] f;
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = !m_rep && (!m_ov || out_ready);
            acc = in_valid && rdy;
            f   = ref_flags(in_data, in_sel);
            if (acc) begin
                m_ov = 1; m_flags = f; m_msk = ref_masked(in_data, in_mask);
            end else if (out_ready) begin
                m_ov = 0;
            end
`ifdef REDUCTION_PARITY_CHECK_EN
            if (clear) m_perr = 0;
            else if (acc && (f[1] != in_par_exp)) m_perr = 1;
`endif
            if (clear) begin
                m_rep = 0; m_n = 0; m_ca = 0; m_cy = 0; m_cp = 0;
            end else if (m_rep) begin
                m_sa = m_pa; m_sy = m_py; m_sp = m_pp; m_rep = 0;
            end else if (acc) begin
                m_n++; m_ca += int'(f[3]); m_cy += int'(f[2]); m_cp += int'(f[1]);
                if (m_n == WINDOW) begin
                    m_pa = m_ca; m_py = m_cy; m_pp = m_cp; m_rep = 1;
                    m_n = 0; m_ca = 0; m_cy = 0; m_cp = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got=%b exp=0", sum_valid); end
        checks++;
        if ({sum_all, sum_any, sum_par} !== '0) begin
            errors++; $display("FAIL reset_sums got=%0d/%0d/%0d exp=0/0/0", sum_all, sum_any, sum_par);
        end
        checks++;
        if ({out_all, out_any, out_par, out_sel_red, out_masked} !== '0) begin
            errors++; $display("FAIL reset_out_data got=%b%b%b%b %h exp=0000 00", out_all, out_any, out_par, out_sel_red, out_masked);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_flags();
        logic [7:0] td [3] = '{8'hFF, 8'h01, 8'h00};
        logic       ts [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] ef [3] = '{4'b1100, 4'b0110, 4'b0000};
        logic [7:0] em [3] = '{8'h3C, 8'hC3, 8'h00};
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, td[i], 8'h3C, ts[i], 1'b1, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL flags_ready[%0d] got=%b exp=1", i, in_ready); end
            cycle();
            checks++;
            if ({out_valid, out_all, out_any, out_par, out_sel_red, out_masked} !== {1'b1, ef[i], em[i]}) begin
                errors++;
                $display("FAIL flags_beat[%0d] got v=%b f=%b%b%b%b m=%h exp v=1 f=%b m=%h",
                         i, out_valid, out_all, out_any, out_par, out_sel_red, out_masked, ef[i], em[i]);
            end
            $display("test_flags: data=%h sel=%b -> flags=%b%b%b%b masked=%h",
                     td[i], ts[i], out_all, out_any, out_par, out_sel_red, out_masked);
        end
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 8'hA5, 8'h0F, 1'b1, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_initial got=%b exp=0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({in_ready, out_valid, out_any, out_masked} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b any=%b m=%h exp rdy=0 v=1 any=0 m=00",
                         i, in_ready, out_valid, out_any, out_masked);
            end
        end
        set_in(1'b1, 8'hA5, 8'h0F, 1'b1, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got=%b exp=1", in_ready); end
        cycle();
        checks++;
        if ({out_valid, out_all, out_any, out_par, out_sel_red, out_masked} !== {1'b1, 4'b0100, 8'hF0}) begin
            errors++;
            $display("FAIL bp_beat got v=%b f=%b%b%b%b m=%h exp v=1 f=0100 m=f0",
                     out_valid, out_all, out_any, out_par, out_sel_red, out_masked);
        end
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        checks++;
        if ({out_valid, out_masked} !== {1'b0, 8'hF0}) begin
            errors++; $display("FAIL bp_drain got v=%b m=%h exp v=0 m=f0", out_valid, out_masked);
        end
        $display("test_backpressure: held 5 cycles, beat A5 delivered masked=%h", out_masked);
    endtask

    task automatic test_window();
        logic [7:0] wd [16] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, wd[i], 8'h55, 1'b0, 1'b1, 1'b0);
            checks++;
            if (sum_valid !== 1'b0) begin errors++; $display("FAIL window_early_pulse[%0d] got=%b exp=0", i, sum_valid); end
            cycle();
        end
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({sum_valid, in_ready, sum_all, sum_any, sum_par} !== {1'b1, 1'b0, 5'd3, 5'd10, 5'd7}) begin
            errors++;
            $display("FAIL window_report got sv=%b rdy=%b sums=%0d/%0d/%0d exp sv=1 rdy=0 sums=3/10/7",
                     sum_valid, in_ready, sum_all, sum_any, sum_par);
        end
        cycle();
        checks++;
        if ({sum_valid, in_ready, sum_all, sum_any, sum_par} !== {1'b0, 1'b1, 5'd3, 5'd10, 5'd7}) begin
            errors++;
            $display("FAIL window_after got sv=%b rdy=%b sums=%0d/%0d/%0d exp sv=0 rdy=1 sums=3/10/7",
                     sum_valid, in_ready, sum_all, sum_any, sum_par);
        end
        $display("test_window: sums=%0d/%0d/%0d", sum_all, sum_any, sum_par);
    endtask

    task automatic test_clear();
        int         ea, ey, ep;
        logic [7:0] d;
        ea = 0; ey = 0; ep = 0;
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, rand_byte(), 8'h5A, 1'b0, 1'b1, (i == 8));
            checks++;
            if (sum_valid !== 1'b0) begin errors++; $display("FAIL clear_pre_pulse[%0d] got=%b exp=0", i, sum_valid); end
            cycle();
        end
        for (int i = 0; i < 16; i++) begin
            d = rand_byte();
            ea += int'(d == 8'hFF); ey += int'(d != 8'h00); ep += $countones(d) % 2;
            set_in(1'b1, d, 8'h5A, 1'b1, 1'b1, 1'b0);
            checks++;
            if (sum_valid !== 1'b0) begin errors++; $display("FAIL clear_post_pulse[%0d] got=%b exp=0", i, sum_valid); end
            cycle();
        end
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({sum_valid, sum_all, sum_any, sum_par} !== {1'b1, CNT_W'(ea), CNT_W'(ey), CNT_W'(ep)}) begin
            errors++;
            $display("FAIL clear_report got sv=%b sums=%0d/%0d/%0d exp sv=1 sums=%0d/%0d/%0d",
                     sum_valid, sum_all, sum_any, sum_par, ea, ey, ep);
        end
        cycle();
        $display("test_clear: sums=%0d/%0d/%0d", sum_all, sum_any, sum_par);
    endtask

`ifdef REDUCTION_PARITY_CHECK_EN
    task automatic test_parity();
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle();
        checks++;
        if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear0 got=%b exp=0", par_err); end
        in_par_exp = 1'b0;
        set_in(1'b1, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        checks++;
        if (par_err !== 1'b1) begin errors++; $display("FAIL par_set got=%b exp=1", par_err); end
        set_in(1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        checks++;
        if (par_err !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b exp=1", par_err); end
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle();
        checks++;
        if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear1 got=%b exp=0", par_err); end
        $display("test_parity: done");
    endtask
`endif

    task automatic test_random();
        bit         exp_rdy, exp_sv;
        logic [3:0] got_f;
        for (int i = 0; i < 400; i++) begin
`ifdef REDUCTION_PARITY_CHECK_EN
            in_par_exp = 1'($urandom);
`endif
            set_in(($urandom_range(0, 3) != 0), rand_byte(), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
            exp_rdy = !m_rep && (!m_ov || out_ready);
            exp_sv  = m_rep && !clear;
            checks++;
            if ({in_ready, sum_valid} !== {exp_rdy, exp_sv}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got rdy=%b sv=%b exp rdy=%b sv=%b", i, in_ready, sum_valid, exp_rdy, exp_sv);
            end
            checks++;
            if ({sum_all, sum_any, sum_par} !== (exp_sv ? {CNT_W'(m_pa), CNT_W'(m_py), CNT_W'(m_pp)}
                                                        : {CNT_W'(m_sa), CNT_W'(m_sy), CNT_W'(m_sp)})) begin
                errors++;
                $display("FAIL rand_sums[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, sum_all, sum_any, sum_par,
                         exp_sv ? m_pa : m_sa, exp_sv ? m_py : m_sy, exp_sv ? m_pp : m_sp);
            end
            cycle();
            got_f = {out_all, out_any, out_par, out_sel_red};
            checks++;
            if ({out_valid, got_f, out_masked} !== {m_ov, m_flags, m_msk}) begin
                errors++;
                $display("FAIL rand_out[%0d] got v=%b f=%b m=%h exp v=%b f=%b m=%h",
                         i, out_valid, got_f, out_masked, m_ov, m_flags, m_msk);
            end
`ifdef REDUCTION_PARITY_CHECK_EN
            checks++;
            if (par_err !== m_perr) begin errors++; $display("FAIL rand_par_err[%0d] got=%b exp=%b", i, par_err, m_perr); end
`endif
        end
        $display("test_random: 400 cycles");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_flags();
        test_backpressure();
        test_window();
        test_clear();
`ifdef REDUCTION_PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
